// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the buffered UART: register map, STATUS/IRQ_EN
// bit positions, the serial FSM state encoding and the baud-divisor floor.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_IRQ_EN = 2'd3;

    localparam int STAT_RX_NONEMPTY = 0;
    localparam int STAT_TX_FULL     = 1;
    localparam int STAT_TX_EMPTY    = 2;
    localparam int STAT_TX_BUSY     = 3;
    localparam int STAT_RX_OVERRUN  = 4;
    localparam int STAT_FRAME_ERR   = 5;
    localparam int STAT_TX_DROP     = 6;

    localparam int IE_RX_NONEMPTY = 0;
    localparam int IE_TX_EMPTY    = 1;
    localparam int IE_ERROR       = 2;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_e;

    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
// Single-clock FIFO with first-word fall-through head data; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/uart_fifo.sv
`timescale 1ns/1ps
// Memory-mapped UART with TX/RX FIFOs, programmable divisor, sticky errors and a
// maskable level interrupt; bit timing and both serial FSMs live here.
module uart_fifo #(
    parameter int DEPTH       = 16,
    parameter int DEFAULT_DIV = 434,
    parameter int STOP_BITS   = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WE,
    input  logic        RE,
    input  logic [1:0]  A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ,
    output logic        UART_TX,
    input  logic        UART_RX
);

    import uart_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;

    logic [15:0] div_q, div_d;
    logic [2:0]  irq_en_q, irq_en_d;
    logic        rx_overrun_q, rx_overrun_d;
    logic        frame_err_q, frame_err_d;
    logic        tx_drop_q, tx_drop_d;
    logic [2:0]  sticky_clr;
    logic [31:0] status;
    logic        unused_wd;

    uart_state_e tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        tx_stop_q, tx_out_q;
    logic        tx_bit_end, tx_last_stop;

    uart_state_e rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic [1:0]  rx_sync_q;
    logic        rx_prev_q, rx_s, rx_bit_end, rx_stop_sample;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk_i(CLK), .rst_ni(RESET), .push_i(tx_push), .data_i(WD[7:0]), .pop_i(tx_pop),
        .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk_i(CLK), .rst_ni(RESET), .push_i(rx_push), .data_i(rx_shift_q), .pop_i(rx_pop),
        .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
    );

    assign tx_push        = WE && (A == ADDR_DATA);
    assign rx_pop         = RE && (A == ADDR_DATA);
    assign tx_bit_end     = (tx_cnt_q == '0);
    assign tx_last_stop   = (tx_stop_q == 1'(STOP_BITS - 1));
    assign tx_pop         = !tx_empty && ((tx_state_q == S_IDLE) ||
                            (tx_state_q == S_STOP && tx_bit_end && tx_last_stop));
    assign rx_s           = rx_sync_q[1];
    assign rx_bit_end     = (rx_cnt_q == '0);
    assign rx_stop_sample = (rx_state_q == S_STOP) && rx_bit_end;
    assign rx_push        = rx_stop_sample && rx_s;
    assign sticky_clr     = (WE && A == ADDR_STATUS) ? WD[STAT_TX_DROP:STAT_RX_OVERRUN] : 3'b000;
    assign unused_wd      = ^WD[31:16];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        div_d    = div_q;
        irq_en_d = irq_en_q;
        if (WE && A == ADDR_DIV)    div_d    = clamp_div(WD[15:0]);
        if (WE && A == ADDR_IRQ_EN) irq_en_d = WD[2:0];
        // A same-cycle set beats a software clear.
        rx_overrun_d = (rx_overrun_q && !sticky_clr[0]) || (rx_push && rx_full && !rx_pop);
        frame_err_d  = (frame_err_q && !sticky_clr[1]) || (rx_stop_sample && !rx_s);
        tx_drop_d    = (tx_drop_q && !sticky_clr[2]) || (tx_push && tx_full && !tx_pop);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div_q        <= 16'(DEFAULT_DIV);
            irq_en_q     <= '0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_drop_q    <= 1'b0;
        end else begin
            div_q        <= div_d;
            irq_en_q     <= irq_en_d;
            rx_overrun_q <= rx_overrun_d;
            frame_err_q  <= frame_err_d;
            tx_drop_q    <= tx_drop_d;
        end
    end

    // Each bit reloads its counter from div_q, so a new divisor applies from the next bit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_stop_q  <= 1'b0;
            tx_out_q   <= 1'b1;
        end else begin
            case (tx_state_q)
                S_IDLE: if (tx_pop) begin
                    tx_state_q <= S_START;
                    tx_shift_q <= tx_head;
                    tx_out_q   <= 1'b0;
                    tx_cnt_q   <= div_q - 16'd1;
                end
                S_START: if (!tx_bit_end) tx_cnt_q <= tx_cnt_q - 16'd1;
                else begin
                    tx_state_q <= S_DATA;
                    tx_out_q   <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_bit_q   <= '0;
                    tx_cnt_q   <= div_q - 16'd1;
                end
                S_DATA: if (!tx_bit_end) tx_cnt_q <= tx_cnt_q - 16'd1;
                else begin
                    tx_cnt_q <= div_q - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_q <= S_STOP;
                        tx_out_q   <= 1'b1;
                        tx_stop_q  <= 1'b0;
                    end else begin
                        tx_bit_q   <= tx_bit_q + 3'd1;
                        tx_out_q   <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                    end
                end
                S_STOP: if (!tx_bit_end) tx_cnt_q <= tx_cnt_q - 16'd1;
                else if (!tx_last_stop) begin
                    tx_stop_q <= 1'b1;
                    tx_cnt_q  <= div_q - 16'd1;
                end else if (tx_pop) begin
                    tx_state_q <= S_START;
                    tx_shift_q <= tx_head;
                    tx_out_q   <= 1'b0;
                    tx_cnt_q   <= div_q - 16'd1;
                end else begin
                    tx_state_q <= S_IDLE;
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], UART_RX};
            rx_prev_q <= rx_s;
            case (rx_state_q)
                S_IDLE: if (rx_prev_q && !rx_s) begin
                    rx_state_q <= S_START;
                    rx_cnt_q   <= (div_q >> 1) - 16'd1;
                end
                S_START: if (!rx_bit_end) rx_cnt_q <= rx_cnt_q - 16'd1;
                else if (rx_s) rx_state_q <= S_IDLE;
                else begin
                    rx_state_q <= S_DATA;
                    rx_bit_q   <= '0;
                    rx_cnt_q   <= div_q - 16'd1;
                end
                S_DATA: if (!rx_bit_end) rx_cnt_q <= rx_cnt_q - 16'd1;
                else begin
                    rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                    rx_cnt_q   <= div_q - 16'd1;
                    if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
                    else                  rx_bit_q   <= rx_bit_q + 3'd1;
                end
                S_STOP: if (!rx_bit_end) rx_cnt_q <= rx_cnt_q - 16'd1;
                else rx_state_q <= S_IDLE;
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        status                   = '0;
        status[STAT_RX_NONEMPTY] = !rx_empty;
        status[STAT_TX_FULL]     = tx_full;
        status[STAT_TX_EMPTY]    = tx_empty;
        status[STAT_TX_BUSY]     = (tx_state_q != S_IDLE);
        status[STAT_RX_OVERRUN]  = rx_overrun_q;
        status[STAT_FRAME_ERR]   = frame_err_q;
        status[STAT_TX_DROP]     = tx_drop_q;
        status[15:8]             = 8'(rx_count);
        status[23:16]            = 8'(tx_count);
        RD = '0;
        case (A)
            ADDR_DATA:   RD = rx_empty ? 32'd0 : {24'd0, rx_head};
            ADDR_STATUS: RD = status;
            ADDR_DIV:    RD = {16'd0, div_q};
            default:     RD = {29'd0, irq_en_q};
        endcase
    end

    assign IRQ = |(irq_en_q & {rx_overrun_q | frame_err_q | tx_drop_q, tx_empty, !rx_empty});
    assign UART_TX = tx_out_q;

endmodule

// File: tb/tb_uart_fifo.sv
`timescale 1ns/1ps
// Directed bench for uart_fifo: TX frames and DATA reads go through scoreboard queues
// checked by independent monitors; register state is checked against hand-derived values.
module tb_uart_fifo;

    import uart_pkg::*;

    localparam int DEPTH       = 16;
    localparam int DEFAULT_DIV = 434;

    logic        CLK = 1'b0, RESET = 1'b1, WE = 1'b0, RE = 1'b0;
    logic [1:0]  A = 2'd0;
    logic [31:0] WD = '0;
    logic [31:0] RD;
    logic        IRQ, UART_TX, UART_RX;
    logic        rx_drv = 1'b1, loop_en = 1'b0;

    assign UART_RX = loop_en ? UART_TX : rx_drv;

    uart_fifo #(.DEPTH(DEPTH), .DEFAULT_DIV(DEFAULT_DIV), .STOP_BITS(1)) dut (
        .CLK(CLK), .RESET(RESET), .WE(WE), .RE(RE), .A(A), .WD(WD), .RD(RD),
        .IRQ(IRQ), .UART_TX(UART_TX), .UART_RX(UART_RX)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int         n_tests = 0, n_fail = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         tx_starts[$];
    int         tx_frames = 0;
    bit         tx_mon_en = 1'b0;
    int         mon_div = 4;
    int         wr_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        A = a; WD = d; WE = 1'b1;
        @(posedge CLK); #1;
        WE = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, input string name, input logic [31:0] exp);
        A = a;
        @(negedge CLK);
        check(name, RD, exp);
        @(posedge CLK); #1;
    endtask

    task automatic read_data();
        A = ADDR_DATA; RE = 1'b1;
        @(posedge CLK); #1;
        RE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_tx_frames(input int n, input int budget);
        int k = 0;
        while (tx_frames < n && k < budget) begin
            @(posedge CLK);
            k++;
        end
        @(posedge CLK); #1;
        check("tx_frames_done", 32'(tx_frames), 32'(n));
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            repeat (d) @(posedge CLK);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    // Serial-line monitor: decodes each frame on UART_TX, checks every cycle of it.
    initial begin
        forever begin
            @(negedge CLK);
            if (tx_mon_en && UART_TX === 1'b0) begin
                logic [7:0] b, got;
                bit         ok;
                int         d;
                tx_starts.push_back(cyc);
                d   = mon_div;
                ok  = 1'b1;
                got = '0;
                if (tx_exp.size() == 0) begin
                    b  = 8'h00;
                    ok = 1'b0;
                end else begin
                    b = tx_exp.pop_front();
                end
                for (int c = 0; c < 10 * d; c++) begin
                    logic e;
                    if (c > 0) @(negedge CLK);
                    e = (c < d) ? 1'b0 : (c < 9 * d) ? b[c / d - 1] : 1'b1;
                    if (UART_TX !== e) ok = 1'b0;
                    if (c >= d && c < 9 * d && (c % d) == d / 2) got[c / d - 1] = UART_TX;
                end
                tx_frames++;
                check("tx_frame_byte", {24'd0, got}, {24'd0, b});
                check("tx_frame_timing", {31'd0, ok}, 32'd1);
            end
        end
    end

    // Read-data monitor: every DATA read is compared with the next expected RX byte (0 when none).
    initial begin
        forever begin
            @(negedge CLK);
            if (RE && A == ADDR_DATA) begin
                logic [7:0] e;
                if (rx_exp.size() > 0) e = rx_exp.pop_front();
                else                   e = 8'h00;
                check("rx_data", RD, {24'd0, e});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #2 RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        idle(1);

        read_reg(ADDR_DATA, "rst_data", 32'h0);
        read_reg(ADDR_STATUS, "rst_status", 32'h0000_0004);
        check("rst_uart_tx", 32'(UART_TX), 32'd1);
        check("rst_irq", 32'(IRQ), 32'd0);
        read_reg(ADDR_DIV, "rst_div", 32'(DEFAULT_DIV));
        read_reg(ADDR_IRQ_EN, "rst_irq_en", 32'h0);
        reg_write(ADDR_DIV, 32'd2);
        read_reg(ADDR_DIV, "div_clamp", 32'd4);

        mon_div   = 4;
        tx_mon_en = 1'b1;
        tx_exp.push_back(8'h55);
        tx_exp.push_back(8'hA3);
        reg_write(ADDR_DATA, 32'h55);
        wr_cyc = cyc;
        reg_write(ADDR_DATA, 32'hA3);
        wait_tx_frames(2, 400);
        check("tx_first_start_latency", 32'(tx_starts[0] - wr_cyc), 32'd1);
        check("tx_back_to_back_gap", 32'(tx_starts[1] - tx_starts[0]), 32'd40);
        read_reg(ADDR_STATUS, "tx_done_status", 32'h0000_0004);

        reg_write(ADDR_DIV, 32'd8);
        mon_div = 8;
        reg_write(ADDR_IRQ_EN, 32'd1);
        check("irq_idle", 32'(IRQ), 32'd0);
        loop_en = 1'b1;
        tx_exp.push_back(8'h3C);
        rx_exp.push_back(8'h3C);
        reg_write(ADDR_DATA, 32'h3C);
        wait_tx_frames(3, 400);
        read_reg(ADDR_STATUS, "loop_status", 32'h0000_0105);
        check("irq_rx_nonempty", 32'(IRQ), 32'd1);
        read_data();
        read_reg(ADDR_STATUS, "loop_drained", 32'h0000_0004);
        check("irq_rx_cleared", 32'(IRQ), 32'd0);
        read_data();
        loop_en = 1'b0;

        reg_write(ADDR_IRQ_EN, 32'd4);
        send_rx(8'hA5, 1'b0, 8);
        idle(4);
        read_reg(ADDR_STATUS, "frame_err_status", 32'h0000_0024);
        check("irq_frame_err", 32'(IRQ), 32'd1);
        reg_write(ADDR_STATUS, 32'h20);
        read_reg(ADDR_STATUS, "frame_err_cleared", 32'h0000_0004);
        check("irq_err_cleared", 32'(IRQ), 32'd0);

        rx_drv = 1'b0;
        @(posedge CLK); #1;
        rx_drv = 1'b1;
        idle(100);
        read_reg(ADDR_STATUS, "glitch_ignored", 32'h0000_0004);

        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = 8'(i * 13 + 5);
            if (i < 16) rx_exp.push_back(b);
            send_rx(b, 1'b1, 8);
        end
        idle(4);
        read_reg(ADDR_STATUS, "overrun_status", 32'h0000_1015);
        check("irq_overrun", 32'(IRQ), 32'd1);
        reg_write(ADDR_STATUS, 32'h10);
        read_reg(ADDR_STATUS, "overrun_cleared", 32'h0000_1005);

        rx_exp.push_back(8'h77);
        fork
            send_rx(8'h77, 1'b1, 8);
            begin
                repeat (78) @(posedge CLK);
                #1 A = ADDR_DATA; RE = 1'b1;
                @(posedge CLK); #1;
                RE = 1'b0;
            end
        join
        idle(4);
        read_reg(ADDR_STATUS, "full_push_pop", 32'h0000_1005);
        repeat (16) read_data();
        read_reg(ADDR_STATUS, "rx_drained", 32'h0000_0004);
        check("rx_queue_drained", 32'(rx_exp.size()), 32'd0);

        tx_mon_en = 1'b0;
        reg_write(ADDR_DIV, 32'h0000_FFFF);
        read_reg(ADDR_DIV, "div_max", 32'h0000_FFFF);
        for (int i = 0; i < 18; i++) reg_write(ADDR_DATA, 32'(i));
        read_reg(ADDR_STATUS, "tx_overflow_status", 32'h0010_004A);
        check("irq_tx_drop", 32'(IRQ), 32'd1);
        reg_write(ADDR_STATUS, 32'h40);
        read_reg(ADDR_STATUS, "tx_drop_cleared", 32'h0010_000A);
        check("tx_mid_frame_low", 32'(UART_TX), 32'd0);

        #2 RESET = 1'b0;
        #1 check("reset_tx_immediate", 32'(UART_TX), 32'd1);
        check("reset_irq", 32'(IRQ), 32'd0);
        @(posedge CLK); #1 RESET = 1'b1;
        idle(2);
        read_reg(ADDR_STATUS, "post_reset_status", 32'h0000_0004);
        read_reg(ADDR_DIV, "post_reset_div", 32'(DEFAULT_DIV));
        check("tx_queue_drained", 32'(tx_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
